// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package ifb_pkg;

  localparam int IFB_DEPTH  = 16;
  localparam int IFB_INST_W = 32;
  localparam int IFB_ADDR_W = 32;

  localparam logic ISSUE_SINGLE = 1'b0;
  localparam logic ISSUE_DUAL   = 1'b1;

  typedef struct packed {
    logic [IFB_INST_W-1:0] inst;
    logic [IFB_ADDR_W-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer.sv
// Two-in/two-out circular instruction queue between ICache and dual-issue decode.
module inst_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int DEPTH  = IFB_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int INST_W = IFB_INST_W,
  parameter int ADDR_W = IFB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in1_valid_i,
  input  logic              in2_valid_i,
  input  logic [INST_W-1:0] in1_inst_i,
  input  logic [INST_W-1:0] in2_inst_i,
  input  logic [ADDR_W-1:0] in1_addr_i,
  input  logic [ADDR_W-1:0] in2_addr_i,
  output logic              full_o,
  input  logic              issue_en_i,
  input  logic              issue_dual_i,
  output logic              out1_valid_o,
  output logic              out2_valid_o,
  output logic [INST_W-1:0] out1_inst_o,
  output logic [INST_W-1:0] out2_inst_o,
  output logic [ADDR_W-1:0] out1_addr_o,
  output logic [ADDR_W-1:0] out2_addr_o,
  output logic [PTR_W:0]    count_o
);

  localparam logic [PTR_W:0] FULL_TH = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO = (PTR_W+1)'(2);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       wr_n, rd_n;
  logic             full, push_ok, wr1_en, wr2_en;

  // Pointer/count next-state; flush overrides any push or pop this cycle.
  always_comb begin
    full    = (count_q > FULL_TH);
    push_ok = in1_valid_i & ~full & ~flush_i;
    wr1_en  = push_ok & rst_n;
    wr2_en  = push_ok & in2_valid_i & rst_n;
    wr_n    = {1'b0, push_ok} + {1'b0, push_ok & in2_valid_i};
    rd_n    = 2'd0;
    if (issue_en_i && !flush_i) begin
      if (issue_dual_i == ISSUE_DUAL && count_q >= CNT_TWO) rd_n = 2'd2;
      else if (count_q >= CNT_ONE)                           rd_n = 2'd1;
    end
    head_p1 = head_q + PTR_W'(1);
    tail_p1 = tail_q + PTR_W'(1);
    head_d  = head_q + PTR_W'(rd_n);
    tail_d  = tail_q + PTR_W'(wr_n);
    count_d = count_q + (PTR_W+1)'(wr_n) - (PTR_W+1)'(rd_n);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (wr1_en) begin
      inst_mem[tail_q] <= in1_inst_i;
      addr_mem[tail_q] <= in1_addr_i;
    end
    if (wr2_en) begin
      inst_mem[tail_p1] <= in2_inst_i;
      addr_mem[tail_p1] <= in2_addr_i;
    end
  end

  always_comb begin
    out1_valid_o = (count_q >= CNT_ONE);
    out2_valid_o = (count_q >= CNT_TWO);
    out1_inst_o  = out1_valid_o ? inst_mem[head_q]  : '0;
    out1_addr_o  = out1_valid_o ? addr_mem[head_q]  : '0;
    out2_inst_o  = out2_valid_o ? inst_mem[head_p1] : '0;
    out2_addr_o  = out2_valid_o ? addr_mem[head_p1] : '0;
    full_o       = full;
    count_o      = count_q;
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed + random bench for inst_fetch_buffer against a queue-based reference model.
module tb_inst_fetch_buffer;
  import ifb_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n, flush_i;
  logic        in1_valid_i, in2_valid_i;
  logic [31:0] in1_inst_i, in2_inst_i, in1_addr_i, in2_addr_i;
  logic        full_o, issue_en_i, issue_dual_i;
  logic        out1_valid_o, out2_valid_o;
  logic [31:0] out1_inst_o, out2_inst_o, out1_addr_o, out2_addr_o;
  logic [4:0]  count_o;

  int checks = 0;
  int failures = 0;
  string phase = "init";
  fetch_entry_t mq[$];

  inst_fetch_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in1_valid_i(in1_valid_i), .in2_valid_i(in2_valid_i),
    .in1_inst_i(in1_inst_i), .in2_inst_i(in2_inst_i),
    .in1_addr_i(in1_addr_i), .in2_addr_i(in2_addr_i),
    .full_o(full_o), .issue_en_i(issue_en_i), .issue_dual_i(issue_dual_i),
    .out1_valid_o(out1_valid_o), .out2_valid_o(out2_valid_o),
    .out1_inst_o(out1_inst_o), .out2_inst_o(out2_inst_o),
    .out1_addr_o(out1_addr_o), .out2_addr_o(out2_addr_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    fetch_entry_t e0, e1;
    int sz;
    sz = mq.size();
    e0 = '0;
    e1 = '0;
    if (sz >= 1) e0 = mq[0];
    if (sz >= 2) e1 = mq[1];
    chk("count", 64'(count_o), 64'(sz));
    chk("full",  64'(full_o), 64'(sz > DEPTH - 2));
    chk("v1",    64'(out1_valid_o), 64'(sz >= 1));
    chk("v2",    64'(out2_valid_o), 64'(sz >= 2));
    chk("inst1", 64'(out1_inst_o), 64'(e0.inst));
    chk("addr1", 64'(out1_addr_o), 64'(e0.addr));
    chk("inst2", 64'(out2_inst_o), 64'(e1.inst));
    chk("addr2", 64'(out2_addr_o), 64'(e1.addr));
  endtask

  task automatic idle();
    rst_n = 1'b1; flush_i = 1'b0;
    in1_valid_i = 1'b0; in2_valid_i = 1'b0;
    in1_inst_i = '0; in2_inst_i = '0; in1_addr_i = '0; in2_addr_i = '0;
    issue_en_i = 1'b0; issue_dual_i = 1'b0;
  endtask

  // One clock: the model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    int sz, want, pops;
    bit full_m;
    @(posedge clk);
    sz = mq.size();
    full_m = (sz > DEPTH - 2);
    if (!rst_n || flush_i) begin
      mq.delete();
    end else begin
      want = issue_dual_i ? 2 : 1;
      pops = issue_en_i ? ((want < sz) ? want : sz) : 0;
      repeat (pops) void'(mq.pop_front());
      if (in1_valid_i && !full_m) begin
        mq.push_back('{inst: in1_inst_i, addr: in1_addr_i});
        if (in2_valid_i) mq.push_back('{inst: in2_inst_i, addr: in2_addr_i});
      end
    end
    #1;
    check_all();
  endtask

  task automatic push2(input logic [31:0] i1, a1, i2, a2);
    idle();
    in1_valid_i = 1'b1; in2_valid_i = 1'b1;
    in1_inst_i = i1; in1_addr_i = a1; in2_inst_i = i2; in2_addr_i = a2;
    tick();
  endtask

  task automatic push1(input logic [31:0] i1, a1);
    idle();
    in1_valid_i = 1'b1; in1_inst_i = i1; in1_addr_i = a1;
    tick();
  endtask

  task automatic pop(input logic dual);
    idle();
    issue_en_i = 1'b1; issue_dual_i = dual;
    tick();
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;

    phase = "reset";
    in1_valid_i = 1'b1; in2_valid_i = 1'b1;
    in1_inst_i = 32'h1111_1111; in2_inst_i = 32'h2222_2222;
    repeat (2) tick();

    phase = "dual_push";
    push2(32'h2400_0001, 32'hBFC0_0000, 32'h2400_0002, 32'hBFC0_0004);
    idle();
    tick();

    phase = "in2_only";
    do_flush();
    push1(32'hAAAA_0001, 32'h0000_1000);
    idle();
    in2_valid_i = 1'b1; in2_inst_i = 32'hDEAD_BEEF; in2_addr_i = 32'h0000_2000;
    tick();

    phase = "fill";
    do_flush();
    for (int i = 0; i < 7; i++)
      push2(32'h100 + 2 * i, 32'h4000 + 8 * i, 32'h101 + 2 * i, 32'h4004 + 8 * i);
    pop(ISSUE_DUAL);
    push1(32'h200, 32'h5000);
    push2(32'h201, 32'h5004, 32'h202, 32'h5008);
    pop(ISSUE_SINGLE);
    push2(32'h203, 32'h500C, 32'h204, 32'h5010);
    phase = "full_pop";
    pop(ISSUE_DUAL);
    pop(ISSUE_SINGLE);

    phase = "wrap";
    do_flush();
    for (int i = 0; i < 15; i++) begin
      push1(32'h300 + i, 32'h6000 + 4 * i);
      pop(ISSUE_SINGLE);
    end
    push2(32'hA5A5_000A, 32'h7000_0000, 32'hB5B5_000B, 32'h7000_0004);
    pop(ISSUE_DUAL);
    push2(32'hC0DE_0001, 32'h7100_0000, 32'hC0DE_0002, 32'h7100_0004);

    phase = "flush5";
    do_flush();
    push2(32'h501, 32'h8000, 32'h502, 32'h8004);
    push2(32'h503, 32'h8008, 32'h504, 32'h800C);
    push1(32'h505, 32'h8010);
    idle();
    flush_i = 1'b1; in1_valid_i = 1'b1; in2_valid_i = 1'b1;
    in1_inst_i = 32'hF1; in2_inst_i = 32'hF2;
    issue_en_i = 1'b1; issue_dual_i = 1'b1;
    tick();
    push1(32'h600, 32'h9000);
    idle();
    tick();

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      idle();
      rst_n        = ($urandom_range(0, 79) != 0);
      flush_i      = ($urandom_range(0, 39) == 0);
      in1_valid_i  = ($urandom_range(0, 3) != 0) && (mq.size() <= DEPTH - 2);
      in2_valid_i  = $urandom_range(0, 1);
      in1_inst_i   = $urandom;
      in2_inst_i   = $urandom;
      in1_addr_i   = $urandom;
      in2_addr_i   = $urandom;
      issue_en_i   = ($urandom_range(0, 2) == 0);
      issue_dual_i = $urandom_range(0, 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
